// File: rtl/parking_lot_pkg.sv
// Shared types and constants for the multi-gate parking-lot occupancy tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the per-gate sequence-detector state enum, the encodings of the
// synchronised {a,b} sensor pair, and the counter width helper.
package parking_lot_pkg;

    // Per-gate sequence detector states. EN* track an entry in progress,
    // EX* track an exit in progress.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EN1  = 3'd1,
        ST_EN2  = 3'd2,
        ST_EN3  = 3'd3,
        ST_EX1  = 3'd4,
        ST_EX2  = 3'd5,
        ST_EX3  = 3'd6
    } gate_state_t;

    // Synchronised sensor pair, packed as {a, b}; 1 = beam blocked.
    localparam logic [1:0] AB_CLEAR = 2'b00;  // neither beam blocked
    localparam logic [1:0] AB_OUTER = 2'b10;  // only outer beam blocked
    localparam logic [1:0] AB_INNER = 2'b01;  // only inner beam blocked
    localparam logic [1:0] AB_BOTH  = 2'b11;  // vehicle spans both beams

    // Bits needed to hold 0..capacity inclusive.
    function automatic int cnt_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/gate_fsm.sv
// One gate: sensor synchroniser plus entry/exit sequence detector.
// Latency: SYNC_STAGES edges raw->synced, +1 edge synced final 00 -> pulse.
// Backpressure: none; pulses are fire-and-forget one-cycle strobes.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   a, b                  raw outer / inner beam sensors (asynchronous)
//   entry_pulse           registered one-cycle strobe on a completed entry
//   exit_pulse            registered one-cycle strobe on a completed exit
module gate_fsm
    import parking_lot_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic entry_pulse,
    output logic exit_pulse
);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             ab;

    gate_state_t state;
    gate_state_t state_nxt;
    logic        entry_nxt;
    logic        exit_nxt;

    // Plain flop chains; the sensors are slow mechanical events so a
    // per-bit synchroniser is sufficient (a and b may land one cycle apart,
    // which the detector tolerates because every legal step is held).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b};
        end
    end

    assign ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_pulse <= entry_nxt;
            exit_pulse  <= exit_nxt;
        end
    end

    // Entry walks 10 -> 11 -> 01 -> 00; exit is the mirror 01 -> 11 -> 10 -> 00.
    // Backing up one step (e.g. EN2 on 10) is allowed; anything else that
    // breaks the sequence drops back to IDLE. IDLE ignores 11 so a vehicle
    // sitting in the gate across reset never produces a count.
    always_comb begin
        state_nxt = state;
        entry_nxt = 1'b0;
        exit_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ab == AB_OUTER)      state_nxt = ST_EN1;
                else if (ab == AB_INNER) state_nxt = ST_EX1;
            end
            ST_EN1: begin
                if (ab == AB_BOTH)       state_nxt = ST_EN2;
                else if (ab != AB_OUTER) state_nxt = ST_IDLE;
            end
            ST_EN2: begin
                if (ab == AB_INNER)      state_nxt = ST_EN3;
                else if (ab == AB_OUTER) state_nxt = ST_EN1;
                else if (ab == AB_CLEAR) state_nxt = ST_IDLE;
            end
            ST_EN3: begin
                if (ab == AB_BOTH)       state_nxt = ST_EN2;
                else if (ab == AB_OUTER) state_nxt = ST_IDLE;
                else if (ab == AB_CLEAR) begin
                    state_nxt = ST_IDLE;
                    entry_nxt = 1'b1;
                end
            end
            ST_EX1: begin
                if (ab == AB_BOTH)       state_nxt = ST_EX2;
                else if (ab != AB_INNER) state_nxt = ST_IDLE;
            end
            ST_EX2: begin
                if (ab == AB_OUTER)      state_nxt = ST_EX3;
                else if (ab == AB_INNER) state_nxt = ST_EX1;
                else if (ab == AB_CLEAR) state_nxt = ST_IDLE;
            end
            ST_EX3: begin
                if (ab == AB_BOTH)       state_nxt = ST_EX2;
                else if (ab == AB_INNER) state_nxt = ST_IDLE;
                else if (ab == AB_CLEAR) begin
                    state_nxt = ST_IDLE;
                    exit_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/parking_lot_occupancy.sv
// Multi-gate parking-lot occupancy counter with saturation and sticky errors.
// Latency: raw final release to count change is SYNC_STAGES+2 edges.
// Backpressure: none; every completed entry/exit is consumed the cycle it pulses.
//
// Ports:
//   clk, reset                system clock, async active-high reset
//   a, b [N_GATES]            raw outer / inner beam sensors per gate
//   err_clr                   synchronous clear of ovf_err / udf_err (set wins)
//   count [CNT_W]             registered occupancy, saturates at 0 and CAPACITY
//   full, empty               decodes of count
//   ovf_err, udf_err          sticky: entry discarded at capacity / exit at zero
//   entry_pulse, exit_pulse   per-gate one-cycle completion strobes
module parking_lot_occupancy
    import parking_lot_pkg::*;
#(
    parameter  int N_GATES     = 2,
    parameter  int CAPACITY    = 9,
    parameter  int SYNC_STAGES = 2,
    localparam int CNT_W       = cnt_width(CAPACITY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] a,
    input  logic [N_GATES-1:0] b,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               ovf_err,
    output logic               udf_err,
    output logic [N_GATES-1:0] entry_pulse,
    output logic [N_GATES-1:0] exit_pulse
);

    // Four guard bits hold up to +/-8 simultaneous events plus a sign.
    localparam int SUM_W = CNT_W + 4;
    localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

    logic [3:0]              n_ent;
    logic [3:0]              n_ext;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf_evt;
    logic                    udf_evt;
    logic [CNT_W-1:0]        count_nxt;

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        gate_fsm #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gate_fsm (
            .clk         (clk),
            .reset       (reset),
            .a           (a[g]),
            .b           (b[g]),
            .entry_pulse (entry_pulse[g]),
            .exit_pulse  (exit_pulse[g])
        );
    end

    // Entries and exits from the same cycle net out before the clamp, so a
    // full lot with one car in and one car out is neither changed nor flagged.
    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int i = 0; i < N_GATES; i++) begin
            n_ent = n_ent + {3'b000, entry_pulse[i]};
            n_ext = n_ext + {3'b000, exit_pulse[i]};
        end
        sum = $signed({4'b0000, count})
            + $signed({{CNT_W{1'b0}}, n_ent})
            - $signed({{CNT_W{1'b0}}, n_ext});

        ovf_evt   = (sum > CAP_S);
        udf_evt   = sum[SUM_W-1];
        count_nxt = sum[CNT_W-1:0];
        if (ovf_evt)      count_nxt = CNT_W'(CAPACITY);
        else if (udf_evt) count_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            count   <= count_nxt;
            // A fresh event in the clear cycle keeps the flag set.
            ovf_err <= ovf_evt | (ovf_err & ~err_clr);
            udf_err <= udf_evt | (udf_err & ~err_clr);
        end
    end

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule
